// File: rtl/wave_capture.sv
// wave_capture: triggered single-frame capture of a DDS sample stream.
// A decimated sample tick primes/evaluates a level-crossing trigger; on
// trigger (or auto timeout) DEPTH samples are written to a RAM and held
// for a reader.
// Optional build macro WAVE_CAPTURE_MINMAX_EN adds frame_min/frame_max.
//
// Handshake: frame_valid rises the cycle after the last sample of a frame is
// written and stays high until the reader pulses frame_ack for one cycle;
// frame_ack is only honoured while frame_valid is high (DONE), and it takes
// priority over a simultaneous arm.
module wave_capture #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] din,
  input  logic [15:0]       decim,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic              arm,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              busy,
  output logic              auto_trig,
`ifdef WAVE_CAPTURE_MINMAX_EN
  output logic [DATA_W-1:0] frame_min,
  output logic [DATA_W-1:0] frame_max,
`endif
  output logic [2:0]        state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         decim_q;
  logic [DATA_W-1:0]   level_q;
  logic                edge_q;
  logic [1:0]          mode_q;
  logic [15:0]         div_cnt;
  logic [DATA_W-1:0]   prev_q;
  logic [TO_W-1:0]     to_cnt;
  logic [ADDR_W:0]     wptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                tick;
  logic                trig_hit;
  logic                timeout_hit;
  logic                latch_cfg;
  logic                enter_arm;
  logic                wr_en;
  logic                wr_first;
  logic                forced;
  logic                last_wr;
  logic [ADDR_W-1:0]   wr_addr;

  assign busy    = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign state_o = state_q;
  assign tick    = busy && (div_cnt == decim_q);

  // Crossing detector: the current tick's din against the previous tick's sample.
  assign trig_hit = edge_q ? ((prev_q > level_q) && (din <= level_q))
                           : ((prev_q < level_q) && (din >= level_q));
  assign timeout_hit = (mode_q == 2'd0) && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
  assign wr_addr     = wr_first ? '0 : wptr[ADDR_W-1:0];

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    enter_arm = 1'b0;
    wr_en     = 1'b0;
    wr_first  = 1'b0;
    forced    = 1'b0;
    last_wr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_ARM;
          latch_cfg = 1'b1;
          enter_arm = 1'b1;
        end
      end
      S_ARM: begin
        if (tick) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick && (trig_hit || timeout_hit)) begin
          wr_en    = 1'b1;
          wr_first = 1'b1;
          forced   = !trig_hit;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          wr_en = 1'b1;
          if (wptr == (ADDR_W+1)'(DEPTH - 1)) begin
            last_wr = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (frame_ack) begin
          if (mode_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_ARM;
            latch_cfg = 1'b1;
            enter_arm = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, configuration, counters and frame status registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      decim_q     <= '0;
      level_q     <= '0;
      edge_q      <= 1'b0;
      mode_q      <= 2'd0;
      div_cnt     <= '0;
      prev_q      <= '0;
      to_cnt      <= '0;
      wptr        <= '0;
      frame_valid <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        decim_q <= decim;
        level_q <= trig_level;
        edge_q  <= trig_edge;
        mode_q  <= trig_mode;
      end
      if (enter_arm || !busy || tick) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 16'd1;
      if (tick && ((state_q == S_ARM) || (state_q == S_WAIT))) prev_q <= din;
      if (enter_arm)                         to_cnt <= '0;
      else if (tick && (state_q == S_WAIT))  to_cnt <= to_cnt + 1'b1;
      if (enter_arm)     wptr <= '0;
      else if (wr_first) wptr <= (ADDR_W+1)'(1);
      else if (wr_en)    wptr <= wptr + 1'b1;
      if (last_wr)                              frame_valid <= 1'b1;
      else if ((state_q == S_DONE) && frame_ack) frame_valid <= 1'b0;
      if (wr_first) auto_trig <= forced;
    end
  end

  // Capture RAM write port; contents are deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Registered read port, available in every state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

`ifdef WAVE_CAPTURE_MINMAX_EN
  logic [DATA_W-1:0] min_run, max_run, min_nxt, max_nxt;
  assign min_nxt = (din < min_run) ? din : min_run;
  assign max_nxt = (din > max_run) ? din : max_run;

  // Running min/max seeded by the trigger sample, published at frame end.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      min_run   <= '0;
      max_run   <= '0;
      frame_min <= '0;
      frame_max <= '0;
    end else begin
      if (wr_first) begin
        min_run <= din;
        max_run <= din;
      end else if (wr_en) begin
        min_run <= min_nxt;
        max_run <= max_nxt;
      end
      if (last_wr) begin
        frame_min <= min_nxt;
        frame_max <= max_nxt;
      end
    end
  end
`endif

endmodule
